// File: rtl/vga_pkg.sv
// Shared VGA constants and the draw arbiter state encoding.
// The screen limits are sized to the coordinate buses so that comparisons against them need no widening.
package vga_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    localparam logic [X_W-1:0] X_SCREEN_PIXELS = 8'd160;
    localparam logic [Y_W-1:0] Y_SCREEN_PIXELS = 7'd120;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_OWN     = 2'd1;
    localparam arb_state_t ST_RELEASE = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Returns the first set request at or after ptr, wrapping modulo NUM_REQ, as a one-hot winner.
module rr_pick
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            idx = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : sum[PW-1:0];
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/draw_arbiter.sv
// Shares the VGA pixel port among sprite drawers: round-robin grant, registered pixel path,
// and a hold limit that forcibly revokes a grant from a drawer that never signals done.
module draw_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_colour,
    input  logic [NUM_REQ-1:0]   req_plot,
    input  logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           xout,
    output logic [6:0]           yout,
    output logic [2:0]           colour_out,
    output logic                 plot_out,
    output logic                 busy,
    output logic                 timeout,
    output logic [1:0]           state_dbg
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      gidx_q, gidx_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [C_W-1:0]     c_q, c_d;
    logic               plot_q, plot_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] pick_win;
    logic               pick_valid;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      next_ptr;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [C_W-1:0]     sel_c;
    logic               sel_plot;
    logic               rel;
    logic               hold_hit;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) win_idx = PW'(i);
        end
    end

    // Only the owner's slice is ever routed; other requesters cannot reach the outputs.
    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_c    = '0;
        sel_plot = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == PW'(i)) begin
                sel_x    = req_x[8*i +: 8];
                sel_y    = req_y[7*i +: 7];
                sel_c    = req_colour[3*i +: 3];
                sel_plot = req_plot[i];
            end
        end
    end

    assign next_ptr = (gidx_q == PW'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        c_d       = c_q;
        plot_d    = 1'b0;
        timeout_d = 1'b0;
        rel       = 1'b0;
        hold_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_OWN;
                    grant_d = pick_win;
                    gidx_d  = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                x_d      = sel_x;
                y_d      = sel_y;
                c_d      = sel_c;
                rel      = req_done[gidx_q] || !req[gidx_q];
                hold_hit = (cnt_q == CW'(HOLD_MAX-1));
                if (rel || hold_hit) begin
                    // A normal release wins over a simultaneous hold-limit hit.
                    state_d   = ST_RELEASE;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    timeout_d = !rel;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    plot_d = sel_plot && (sel_x < X_SCREEN_PIXELS) && (sel_y < Y_SCREEN_PIXELS);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            c_q       <= '0;
            plot_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            c_q       <= c_d;
            plot_q    <= plot_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant      = grant_q;
    assign xout       = x_q;
    assign yout       = y_q;
    assign colour_out = c_q;
    assign plot_out   = plot_q;
    assign busy       = (state_q != ST_IDLE);
    assign timeout    = timeout_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sprite requesters (rocket, aliens, bullets, score) sharing the VGA pixel port.
REQ-002 Parameter HOLD_MAX, default 4096: maximum cycles one requester may hold the grant.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester draw request, level, held until done.
REQ-006 req_x  input  8*NUM_REQ  packed pixel x per requester, slice i = bits [8i+7:8i].
REQ-007 req_y  input  7*NUM_REQ  packed pixel y per requester.
REQ-008 req_colour  input  3*NUM_REQ  packed pixel colour per requester.
REQ-009 req_plot  input  NUM_REQ  per-requester pixel-write strobe.
REQ-010 req_done  input  NUM_REQ  per-requester one-cycle pulse: sprite fully drawn.
REQ-011 grant  output  NUM_REQ  one-hot (or zero) ownership of the pixel port.
REQ-012 xout  output  8  pixel x to VGA adapter.
REQ-013 yout  output  7  pixel y to VGA adapter.
REQ-014 colour_out  output  3  pixel colour to VGA adapter.
REQ-015 plot_out  output  1  VGA write enable.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-018 FSM states SHALL be IDLE, OWN, RELEASE; encoding per shared package.
REQ-019 IDLE: grant=0, plot_out=0; if any req bit set at cycle t, winner SHALL be first set bit at or after rr pointer ptr (wrapping modulo NUM_REQ), grant[winner]=1 and state=OWN at t+1.
REQ-020 OWN: xout/yout/colour_out SHALL be the granted requester's slices registered one cycle (pixel presented at t appears at t+1).
REQ-021 plot_out SHALL equal registered req_plot[g] AND x<160 AND y<120; out-of-screen pixels are silently dropped.
REQ-022 Non-granted requests SHALL be ignored while in OWN or RELEASE; their inputs never reach the outputs.
REQ-023 In OWN, req_done[g]=1 or req[g]=0 at cycle t SHALL drop grant at t+1, set ptr=(g+1) mod NUM_REQ, enter RELEASE.
REQ-024 Hold counter SHALL clear on entering OWN and increment each OWN cycle; at count HOLD_MAX-1 without done, grant SHALL drop next cycle, timeout pulses that cycle, ptr advances as REQ-023.
REQ-025 Done and timeout condition in the same cycle SHALL be treated as normal release; timeout stays 0.
REQ-026 RELEASE SHALL last exactly one cycle with plot_out=0 (flushes the output register), then IDLE; new arbitration occurs in IDLE, so grant-to-grant gap is minimum 2 cycles.
REQ-027 grant SHALL never have more than one bit set; grant changes only via IDLE->OWN or OWN->RELEASE.
REQ-028 A requester re-asserting req immediately after release SHALL lose to any other pending requester (round-robin fairness).

Reset
REQ-029 reset=0 on a rising edge SHALL force state=IDLE, grant=0, ptr=0, hold counter=0, xout=0, yout=0, colour_out=0, plot_out=0, busy=0, timeout=0, regardless of state, including mid-sprite.
REQ-030 First arbitration after reset release SHALL favour requester 0.

Structure
REQ-031 Shared package vga_pkg SHALL hold X_SCREEN_PIXELS=160, Y_SCREEN_PIXELS=120, coordinate/colour widths and the arbiter state type.
REQ-032 One sub-module rr_pick SHALL implement the combinational round-robin selector (req, ptr -> one-hot winner, valid).
REQ-033 Output mux, hold counter and FSM SHALL reside in draw_arbiter.

Verification
REQ-034 Reset then req=4'b0001, plot pixel (73,105,colour 3'b111) -> grant=0001 next cycle, xout=73,yout=105,plot_out=1 one cycle after presentation.
REQ-035 req=4'b1010 from IDLE with ptr=0 -> grant=0010; after req_done[1], RELEASE one cycle, then grant=1000.
REQ-036 Requester 2 holds req without done for HOLD_MAX=16 -> grant drops after 16 OWN cycles, timeout=1 one cycle, ptr=3.
REQ-037 Granted requester plots (160,5) and (10,120) -> plot_out=0 both; (159,119) -> plot_out=1.
REQ-038 reset=0 asserted mid-OWN with plot active -> next cycle grant=0, plot_out=0, busy=0; following req=4'b1111 grants requester 0.
REQ-039 done and hold-limit coincide -> release occurs, timeout remains 0.
